// File: rtl/mem_read_scheduler.sv
// Round-robin burst scheduler sharing one MEM read port among NUM_REQ requesters.
// Grants bursts, issues one read per cycle and routes returned words to the owner.
`timescale 1ns/1ps
module mem_read_scheduler #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned LOG_NUM_REQ     = 2,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned LOG_MAX_ADDRESS = 16,
  parameter int unsigned LOG_MAX_LEN     = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_in,
  input  logic [NUM_REQ*LOG_MAX_ADDRESS-1:0] addr_in,
  input  logic [NUM_REQ*LOG_MAX_LEN-1:0]     len_in,
  output logic [NUM_REQ-1:0]                 ack_out,
  output logic                               mem_read,
  output logic [LOG_MAX_ADDRESS-1:0]         mem_addr_read,
  input  logic [DATA_WIDTH-1:0]              mem_data_read,
  input  logic                               mem_valid_out,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic [NUM_REQ-1:0]                 valid_out,
  output logic [NUM_REQ-1:0]                 done_out,
  output logic                               busy_out
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                     state, state_d;
  logic [LOG_NUM_REQ-1:0]     rr_ptr, rr_ptr_d;
  logic [LOG_NUM_REQ-1:0]     owner, owner_d;
  logic [LOG_MAX_ADDRESS-1:0] cur_addr, cur_addr_d;
  logic [LOG_MAX_LEN-1:0]     remain, remain_d;
  logic                       mem_last, mem_last_d;
  logic                       inflight, inflight_last;

  logic [NUM_REQ-1:0]         ack_d, valid_d, done_d;
  logic                       mem_read_d, busy_d;
  logic [LOG_MAX_ADDRESS-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0]      data_d;

  logic [LOG_MAX_ADDRESS-1:0] addr_arr [NUM_REQ];
  logic [LOG_MAX_LEN-1:0]     len_arr  [NUM_REQ];

  logic                       found;
  logic [LOG_NUM_REQ-1:0]     win, cand;
  logic [NUM_REQ-1:0]         win_oh, owner_oh;
  logic [LOG_MAX_ADDRESS-1:0] addr_win;
  logic [LOG_MAX_LEN-1:0]     len_win;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k] = addr_in[k*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS];
    assign len_arr[k]  = len_in[k*LOG_MAX_LEN +: LOG_MAX_LEN];
  end

  // Round-robin scan starting at rr_ptr; first set request bit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = LOG_NUM_REQ'((int'(rr_ptr) + i) % int'(NUM_REQ));
      if (!found && req_in[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_oh   = NUM_REQ'(1) << win;
  assign owner_oh = NUM_REQ'(1) << owner;
  assign addr_win = addr_arr[win];
  assign len_win  = len_arr[win];

  // Next-state, read issue and routing.
  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    owner_d    = owner;
    cur_addr_d = cur_addr;
    remain_d   = remain;
    mem_last_d = 1'b0;
    ack_d      = '0;
    valid_d    = '0;
    done_d     = '0;
    mem_read_d = 1'b0;
    mem_addr_d = mem_addr_read;
    data_d     = data_out;

    case (state)
      IDLE: begin
        if (found) begin
          ack_d    = win_oh;
          owner_d  = win;
          rr_ptr_d = LOG_NUM_REQ'((int'(win) + 1) % int'(NUM_REQ));
          if (len_win == '0) begin
            done_d = win_oh;
          end else begin
            state_d    = BURST;
            mem_read_d = 1'b1;
            mem_addr_d = addr_win;
            cur_addr_d = addr_win + LOG_MAX_ADDRESS'(1);
            remain_d   = len_win - LOG_MAX_LEN'(1);
            mem_last_d = (len_win == LOG_MAX_LEN'(1));
          end
        end
      end
      BURST: begin
        // remain counts reads still to issue after the one currently on the port.
        if (remain != '0) begin
          mem_read_d = 1'b1;
          mem_addr_d = cur_addr;
          cur_addr_d = cur_addr + LOG_MAX_ADDRESS'(1);
          remain_d   = remain - LOG_MAX_LEN'(1);
          mem_last_d = (remain == LOG_MAX_LEN'(1));
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Returned words only count when a read was actually issued the cycle before.
    if (mem_valid_out && inflight) begin
      data_d  = mem_data_read;
      valid_d = owner_oh;
      if (inflight_last) begin
        done_d = done_d | owner_oh;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      cur_addr      <= '0;
      remain        <= '0;
      mem_last      <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      ack_out       <= '0;
      mem_read      <= 1'b0;
      mem_addr_read <= '0;
      data_out      <= '0;
      valid_out     <= '0;
      done_out      <= '0;
      busy_out      <= 1'b0;
    end else begin
      state         <= state_d;
      rr_ptr        <= rr_ptr_d;
      owner         <= owner_d;
      cur_addr      <= cur_addr_d;
      remain        <= remain_d;
      mem_last      <= mem_last_d;
      inflight      <= mem_read;
      inflight_last <= mem_read & mem_last;
      ack_out       <= ack_d;
      mem_read      <= mem_read_d;
      mem_addr_read <= mem_addr_d;
      data_out      <= data_d;
      valid_out     <= valid_d;
      done_out      <= done_d;
      busy_out      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_read_scheduler.sv
// Directed bench for mem_read_scheduler with a one-cycle-latency MEM model (mem[i] = i[7:0]).
`timescale 1ns/1ps
module tb_mem_read_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 8;
  localparam int unsigned DW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_in;
  logic [NR*AW-1:0] addr_in;
  logic [NR*LW-1:0] len_in;
  logic [NR-1:0]    ack_out;
  logic             mem_read;
  logic [AW-1:0]    mem_addr_read;
  logic [DW-1:0]    mem_data_read = '0;
  logic             mem_valid_out;
  logic [DW-1:0]    data_out;
  logic [NR-1:0]    valid_out;
  logic [NR-1:0]    done_out;
  logic             busy_out;

  logic mem_valid_q = 1'b0;
  logic stray = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  mem_read_scheduler #(
    .NUM_REQ(NR), .LOG_NUM_REQ(2), .DATA_WIDTH(DW), .LOG_MAX_ADDRESS(AW), .LOG_MAX_LEN(LW)
  ) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .len_in(len_in),
    .ack_out(ack_out), .mem_read(mem_read), .mem_addr_read(mem_addr_read),
    .mem_data_read(mem_data_read), .mem_valid_out(mem_valid_out),
    .data_out(data_out), .valid_out(valid_out), .done_out(done_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_valid_q   <= mem_read;
    mem_data_read <= mem_addr_read[7:0];
  end
  assign mem_valid_out = mem_valid_q | stray;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int k, input logic [AW-1:0] a, input logic [LW-1:0] l);
    addr_in[k*AW +: AW] = a;
    len_in[k*LW +: LW]  = l;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_in = 4'b1111;
    for (int k = 0; k < 4; k++) set_port(k, AW'(16'h0040 + 16*k), 8'd1);
    step(); step(); step();
    n_checks++; if ({ack_out, mem_read, valid_out, done_out, busy_out} !== 14'd0) $display("FAIL reset_ctrl got %b want 0", {ack_out, mem_read, valid_out, done_out, busy_out}); else n_pass++;
    n_checks++; if ({mem_addr_read, data_out} !== 24'd0) $display("FAIL reset_data got %h want 0", {mem_addr_read, data_out}); else n_pass++;
    rst = 1'b1;
    step();
    n_checks++; if (ack_out !== 4'b0001) $display("FAIL reset_first_grant got %b want 0001", ack_out); else n_pass++;
    n_checks++; if (mem_addr_read !== 16'h0040 || mem_read !== 1'b1) $display("FAIL reset_first_read got %h/%b want 0040/1", mem_addr_read, mem_read); else n_pass++;
    req_in = 4'b0000;
    step(); step();
    n_checks++; if (data_out !== 8'h40 || valid_out !== 4'b0001 || done_out !== 4'b0001) $display("FAIL reset_first_data got %h/%b/%b want 40/0001/0001", data_out, valid_out, done_out); else n_pass++;
  endtask

  task automatic test_burst();
    set_port(1, 16'h0010, 8'd3);
    req_in = 4'b0010;
    step();
    n_checks++; if (ack_out !== 4'b0010) $display("FAIL burst_ack got %b want 0010", ack_out); else n_pass++;
    n_checks++; if (mem_read !== 1'b1 || mem_addr_read !== 16'h0010 || busy_out !== 1'b1) $display("FAIL burst_rd0 got %b/%h/%b want 1/0010/1", mem_read, mem_addr_read, busy_out); else n_pass++;
    req_in = 4'b0000;
    step();
    n_checks++; if (mem_addr_read !== 16'h0011 || ack_out !== 4'b0000) $display("FAIL burst_rd1 got %h/%b want 0011/0000", mem_addr_read, ack_out); else n_pass++;
    step();
    n_checks++; if (mem_addr_read !== 16'h0012) $display("FAIL burst_rd2 got %h want 0012", mem_addr_read); else n_pass++;
    n_checks++; if (data_out !== 8'h10 || valid_out !== 4'b0010 || done_out !== 4'b0000) $display("FAIL burst_d0 got %h/%b/%b want 10/0010/0000", data_out, valid_out, done_out); else n_pass++;
    step();
    n_checks++; if (mem_read !== 1'b0 || busy_out !== 1'b1) $display("FAIL burst_drain got %b/%b want 0/1", mem_read, busy_out); else n_pass++;
    n_checks++; if (data_out !== 8'h11 || valid_out !== 4'b0010 || done_out !== 4'b0000) $display("FAIL burst_d1 got %h/%b/%b want 11/0010/0000", data_out, valid_out, done_out); else n_pass++;
    step();
    n_checks++; if (data_out !== 8'h12 || valid_out !== 4'b0010 || done_out !== 4'b0010) $display("FAIL burst_d2 got %h/%b/%b want 12/0010/0010", data_out, valid_out, done_out); else n_pass++;
    n_checks++; if (busy_out !== 1'b0) $display("FAIL burst_idle got %b want 0", busy_out); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    logic [7:0] exp_d;
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) set_port(k, AW'(16'h0040 + 16*k), 8'd1);
    req_in = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      exp_oh = 4'b0001 << g;
      exp_d  = 8'(8'h40 + 16*g);
      step();
      n_checks++; if (ack_out !== exp_oh) $display("FAIL rr_grant%0d got %b want %b", g, ack_out, exp_oh); else n_pass++;
      req_in = req_in & ~exp_oh;
      step(); step();
      n_checks++; if (data_out !== exp_d || valid_out !== exp_oh || done_out !== exp_oh) $display("FAIL rr_data%0d got %h/%b/%b want %h/%b/%b", g, data_out, valid_out, done_out, exp_d, exp_oh, exp_oh); else n_pass++;
    end
    req_in = 4'b0101;
    step();
    n_checks++; if (ack_out !== 4'b0001) $display("FAIL rr_pair0 got %b want 0001", ack_out); else n_pass++;
    req_in = 4'b0100;
    step(); step(); step();
    n_checks++; if (ack_out !== 4'b0100) $display("FAIL rr_pair1 got %b want 0100", ack_out); else n_pass++;
    req_in = 4'b0000;
    step(); step();
  endtask

  task automatic test_addr_wrap();
    set_port(3, 16'hFFFF, 8'd2);
    req_in = 4'b1000;
    step();
    n_checks++; if (ack_out !== 4'b1000 || mem_addr_read !== 16'hFFFF) $display("FAIL wrap_rd0 got %b/%h want 1000/ffff", ack_out, mem_addr_read); else n_pass++;
    req_in = 4'b0000;
    step();
    n_checks++; if (mem_read !== 1'b1 || mem_addr_read !== 16'h0000) $display("FAIL wrap_rd1 got %b/%h want 1/0000", mem_read, mem_addr_read); else n_pass++;
    step();
    n_checks++; if (data_out !== 8'hFF || valid_out !== 4'b1000 || done_out !== 4'b0000) $display("FAIL wrap_d0 got %h/%b/%b want ff/1000/0000", data_out, valid_out, done_out); else n_pass++;
    step();
    n_checks++; if (data_out !== 8'h00 || valid_out !== 4'b1000 || done_out !== 4'b1000) $display("FAIL wrap_d1 got %h/%b/%b want 00/1000/1000", data_out, valid_out, done_out); else n_pass++;
  endtask

  task automatic test_len_zero();
    set_port(3, 16'h0200, 8'd0);
    set_port(0, 16'h0040, 8'd1);
    req_in = 4'b1000;
    step();
    n_checks++; if (ack_out !== 4'b1000 || done_out !== 4'b1000) $display("FAIL len0_ackdone got %b/%b want 1000/1000", ack_out, done_out); else n_pass++;
    n_checks++; if (mem_read !== 1'b0 || busy_out !== 1'b0 || valid_out !== 4'b0000) $display("FAIL len0_noread got %b/%b/%b want 0/0/0000", mem_read, busy_out, valid_out); else n_pass++;
    req_in = 4'b1001;
    step();
    n_checks++; if (ack_out !== 4'b0001 || mem_read !== 1'b1) $display("FAIL len0_rrptr got %b/%b want 0001/1", ack_out, mem_read); else n_pass++;
    req_in = 4'b0000;
    step(); step();
  endtask

  task automatic test_reset_abort();
    set_port(1, 16'h0010, 8'd4);
    req_in = 4'b0010;
    step();
    n_checks++; if (ack_out !== 4'b0010 || mem_addr_read !== 16'h0010) $display("FAIL abort_start got %b/%h want 0010/0010", ack_out, mem_addr_read); else n_pass++;
    req_in = 4'b0000;
    step();
    rst = 1'b0;
    #1;
    n_checks++; if ({ack_out, mem_read, valid_out, done_out, busy_out} !== 14'd0 || {mem_addr_read, data_out} !== 24'd0) $display("FAIL abort_clear got %b/%h want 0/0", {ack_out, mem_read, valid_out, done_out, busy_out}, {mem_addr_read, data_out}); else n_pass++;
    step(); step();
    rst = 1'b1;
    stray = 1'b1;
    step();
    stray = 1'b0;
    n_checks++; if (valid_out !== 4'b0000 || data_out !== 8'h00 || done_out !== 4'b0000) $display("FAIL abort_stray got %b/%h/%b want 0000/00/0000", valid_out, data_out, done_out); else n_pass++;
    set_port(1, 16'h0033, 8'd1);
    req_in = 4'b0010;
    step();
    n_checks++; if (ack_out !== 4'b0010 || mem_addr_read !== 16'h0033) $display("FAIL abort_regrant got %b/%h want 0010/0033", ack_out, mem_addr_read); else n_pass++;
    req_in = 4'b0000;
    step(); step();
    n_checks++; if (data_out !== 8'h33 || valid_out !== 4'b0010 || done_out !== 4'b0010) $display("FAIL abort_data got %h/%b/%b want 33/0010/0010", data_out, valid_out, done_out); else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    req_in = '0;
    addr_in = '0;
    len_in = '0;
    #2;
    test_reset();
    test_burst();
    test_round_robin();
    test_addr_wrap();
    test_len_zero();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
